result_writeback: RTL and testbench
===================================

# result_writeback

Downstream stage of the systolic array. Consumes the serial result stream, requantizes each 16-bit accumulation with an arithmetic shift, zero-point add and saturation, and buffers the results in a small FIFO. It then writes them into the shared Memory write port at consecutive addresses under a grant from the Controller, and reports job completion.

## Interface
Parameters:
- `ADDR_SIZE`, 12: memory address width.
- `WORD_SIZE`, 16: data width, fixed at 16 in this revision.
- `FIFO_DEPTH`, 8: result buffer entries; power of two, at least 2.
- `CNT_SIZE`, 8: width of the job result count.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse that launches a job; sampled only in IDLE.
- `base_addr`  in  ADDR_SIZE: first write address, latched on start.
- `count`  in  CNT_SIZE: number of results in the job, latched on start.
- `shift`  in  4: arithmetic right-shift amount, latched on start.
- `zero_point`  in  16: signed value added after the shift, latched on start.
- `in_valid`  in  1: array result valid.
- `in_data`  in  16: signed array result.
- `in_ready`  out  1: the block accepts `in_data` this cycle.
- `w_en`  out  1: write request to Memory.
- `w_addr`  out  ADDR_SIZE: write address.
- `w_data`  out  16: write data.
- `w_grant`  in  1: Controller grants the write port this cycle.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- IDLE:
  - `start` latches the four job registers and clears the counters `acc_cnt` and `wr_cnt`.
  - If `count` is 0, go to DONE; otherwise go to RUN.
- RUN:
  - `in_ready = !fifo_full && (acc_cnt != count)`.
  - An input is accepted when `in_valid && in_ready`: the transformed value is pushed into the FIFO and `acc_cnt` increments.
  - Go to DRAIN on the cycle `acc_cnt` reaches `count`.
- DRAIN: `in_ready` is 0. Go to DONE on the cycle the final write completes.
- Writes can complete in both RUN and DRAIN, while the FIFO is non-empty.
- DONE: `done` is 1 for this single cycle, then go to IDLE.
- Transform, applied to each input:
  - `t = (in_data >>> shift)`, sign-extended to 17 bits.
  - `y = t + sign-extended zero_point`, in 17-bit signed arithmetic.
  - Saturate `y` to the range [-32768, 32767] before the FIFO push.
- Write handshake:
  - `w_en` is high whenever the FIFO is non-empty and the state is RUN or DRAIN.
  - `w_data` is the FIFO head and `w_addr = base_addr + wr_cnt`, modulo 2^ADDR_SIZE, so addresses wrap from all-ones to 0.
  - A write completes on a cycle with `w_en && w_grant`. On completion the FIFO pops and `wr_cnt` increments.
  - `w_addr` and `w_data` hold stable while `w_en` is high without a grant.
  - `w_grant` while `w_en` is 0 has no effect.
- A push and a pop in the same cycle are both honoured. `in_ready` depends only on `fifo_full` from the previous state, never on `w_grant`.
- `in_valid` in IDLE, DRAIN or DONE is ignored, with `in_ready` at 0 and no data stored.
- `start` outside IDLE is ignored. Job registers change only in IDLE.
- `reset` (synchronous):
  - State goes to IDLE; the FIFO pointers and both counters go to 0.
  - All outputs go to 0.
  - Applies mid-job as well: a pending job is abandoned with no `done` pulse.

## Timing
- Reset value of every output (`in_ready`, `w_en`, `w_addr`, `w_data`, `busy`, `done`) is 0.
- `start` at cycle S: `busy` goes high at S+1, and `in_ready` goes high at S+1 if `count` is nonzero.
- Latency: an input accepted at cycle t produces `w_en` at t+1 with its data; with `w_grant` held, it is written at t+1.
- Throughput is one result per cycle when `w_grant` is held high.
- Last write completing at cycle W: DONE state and `done` high at W+1, IDLE with `busy` low at W+2.
- `count` = 0 with `start` at S: `done` high at S+1, and `w_en` never asserts.

## Test plan
- Basic job: base 0x100, count 3, shift 2, zero_point 5, inputs 100, -8, 40 back-to-back, grant held high.
  - Required writes: (0x100, 30), (0x101, 3), (0x102, 15) on consecutive cycles.
  - Required `done` pulse one cycle after the last write.
- Saturation: shift 0.
  - zero_point 100, input 32700 -> written value 32767.
  - zero_point -100, input -32700 -> written value -32768.
  - shift 15, input -1 -> written value equals zero_point - 1.
- Backpressure: FIFO_DEPTH 8, count 9, grant low, `in_valid` held high.
  - `in_ready` drops after 8 accepts.
  - Raising grant: all 9 values written in order to base..base+8, then `done`.
- Address wrap: base 0xFFE, count 4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Ignored events:
  - count 0 -> `done` at S+1 with no `w_en`.
  - A second `start` during RUN leaves the latched base and count unchanged.
  - `in_valid` in IDLE produces no write.
- Mid-job reset: reset asserted after 2 of 5 results are accepted.
  - Next cycle all outputs are 0 and the state is IDLE, with no `done` pulse.
  - A fresh job then completes normally.

Source files
------------

// File: rtl/result_writeback.sv
// Requantizes the serial array result stream and writes it to memory at consecutive addresses.
// Latency: an accepted input is presented on w_en/w_addr/w_data the next cycle.
// Backpressure: in_ready drops while the result FIFO is full; writes wait for w_grant.
module rw_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;

  // The extra pointer bit separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_dat = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_dat;
  end
endmodule

module result_writeback #(
  parameter int ADDR_SIZE  = 12,
  parameter int WORD_SIZE  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_SIZE   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [CNT_SIZE-1:0]  count,
  input  logic [3:0]           shift,
  input  logic [WORD_SIZE-1:0] zero_point,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 w_en,
  output logic [ADDR_SIZE-1:0] w_addr,
  output logic [WORD_SIZE-1:0] w_data,
  input  logic                 w_grant,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_SIZE-1:0] CNT_ONE = {{(CNT_SIZE-1){1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [ADDR_SIZE-1:0]  base_q;
  logic [CNT_SIZE-1:0]   count_q;
  logic [3:0]            shift_q;
  logic [WORD_SIZE-1:0]  zp_q;
  logic [CNT_SIZE-1:0]   acc_cnt;
  logic [CNT_SIZE-1:0]   wr_cnt;

  logic                  push, pop;
  logic                  fifo_empty, fifo_full;
  logic [WORD_SIZE-1:0]  head_dat;
  logic signed [WORD_SIZE-1:0] shifted;
  logic signed [WORD_SIZE:0]   sum;
  logic [WORD_SIZE-1:0]  sat_dat;

  // One guard bit is enough: shifted and zero_point are both in word range.
  assign shifted = $signed(in_data) >>> shift_q;
  assign sum     = {shifted[WORD_SIZE-1], shifted} + {zp_q[WORD_SIZE-1], zp_q};

  always_comb begin
    sat_dat = sum[WORD_SIZE-1:0];
    if (sum[WORD_SIZE] != sum[WORD_SIZE-1])
      sat_dat = sum[WORD_SIZE] ? {1'b1, {(WORD_SIZE-1){1'b0}}} : {1'b0, {(WORD_SIZE-1){1'b1}}};
  end

  rw_fifo #(.WIDTH(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (sat_dat),
    .pop      (pop),
    .pop_dat  (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = (state == RUN) && !fifo_full && (acc_cnt != count_q);
    w_en      = ((state == RUN) || (state == DRAIN)) && !fifo_empty;
    busy      = (state != IDLE);
    done      = (state == DONE);
    push      = in_valid && in_ready;
    pop       = w_en && w_grant;
    w_addr    = w_en ? base_q + ADDR_SIZE'(wr_cnt) : '0;
    w_data    = w_en ? head_dat : '0;
    case (state)
      IDLE:    if (start) state_nxt = (count == '0) ? DONE : RUN;
      RUN:     if (push && (acc_cnt + CNT_ONE == count_q)) state_nxt = DRAIN;
      DRAIN:   if (pop && (wr_cnt + CNT_ONE == count_q)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      shift_q <= '0;
      zp_q    <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        base_q  <= base_addr;
        count_q <= count;
        shift_q <= shift;
        zp_q    <= zero_point;
        acc_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        if (push) acc_cnt <= acc_cnt + CNT_ONE;
        if (pop)  wr_cnt  <= wr_cnt + CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback with a queue-based reference model checked every cycle.
module tb_result_writeback;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [7:0]  count = '0;
  logic [3:0]  shift = '0;
  logic [15:0] zero_point = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        w_en;
  logic [11:0] w_addr;
  logic [15:0] w_data;
  logic        w_grant = 1'b0;
  logic        busy;
  logic        done;

  result_writeback dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .shift(shift), .zero_point(zero_point), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .w_grant(w_grant), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  bit armed = 0;

  // Reference model: job phase (0 idle, 1 accepting, 2 draining, 3 done) plus a queue of pending results.
  int m_phase = 0, m_base = 0, m_cnt = 0, m_sh = 0, m_zp = 0, m_acc = 0, m_wr = 0;
  int m_q[$];

  int wl_addr[$], wl_data[$], wl_cyc[$];
  int done_cnt = 0, done_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
    end
  endtask

  function automatic int xform(input int d, input int sh, input int zp);
    int v;
    v = (d >>> sh) + zp;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic bit m_rdy();
    return (m_phase == 1) && (m_q.size() < 8) && (m_acc < m_cnt);
  endfunction

  function automatic bit m_wen();
    return ((m_phase == 1) || (m_phase == 2)) && (m_q.size() > 0);
  endfunction

  always @(posedge clk) begin
    bit acc_ok, pop_ok;
    cyc++;
    if (reset) begin
      armed = 1; m_phase = 0; m_q.delete(); m_acc = 0; m_wr = 0;
      m_base = 0; m_cnt = 0; m_sh = 0; m_zp = 0;
    end else if (armed) begin
      acc_ok = in_valid && m_rdy();
      pop_ok = w_grant && m_wen();
      case (m_phase)
        0: if (start) begin
          m_base = base_addr; m_cnt = count; m_sh = shift;
          m_zp = int'($signed(zero_point)); m_acc = 0; m_wr = 0;
          m_phase = (count == 0) ? 3 : 1;
        end
        1, 2: begin
          if (pop_ok) begin void'(m_q.pop_front()); m_wr++; end
          if (acc_ok) begin m_q.push_back(xform(int'($signed(in_data)), m_sh, m_zp)); m_acc++; end
          if (m_phase == 1 && m_acc == m_cnt) m_phase = 2;
          else if (m_phase == 2 && m_wr == m_cnt) m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_phase == 3);
      chk("in_ready", in_ready, m_rdy());
      chk("w_en", w_en, m_wen());
      if (m_wen()) begin
        chk("w_addr", w_addr, (m_base + m_wr) % 4096);
        chk("w_data", $signed(w_data), m_q[0]);
      end
      if (w_en && w_grant) begin
        wl_addr.push_back(int'(w_addr)); wl_data.push_back(int'($signed(w_data))); wl_cyc.push_back(cyc);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic clear_log();
    wl_addr.delete(); wl_data.delete(); wl_cyc.delete();
  endtask

  task automatic start_job(input int b, input int c, input int s, input int z, output int sc);
    base_addr = 12'(b); count = 8'(c); shift = 4'(s); zero_point = 16'(z);
    start = 1'b1;
    tick();
    start = 1'b0;
    sc = cyc;
  endtask

  task automatic feed(input int vals[$]);
    foreach (vals[i]) begin
      int b = 0;
      in_valid = 1'b1; in_data = 16'(vals[i]);
      while (!in_ready && b < 50) begin tick(); b++; end
      if (b >= 50) chk("feed_timeout", 1, 0);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int b = 0;
    while (done_cnt == d0 && b < 100) begin tick(); b++; end
    chk("done_seen", done_cnt, d0 + 1);
    tick();
  endtask

  task automatic check_writes(input string name, input int addrs[$], input int datas[$]);
    chk({name, "_nwrites"}, wl_addr.size(), addrs.size());
    foreach (addrs[i]) begin
      if (i < wl_addr.size()) begin
        chk({name, "_addr"}, wl_addr[i], addrs[i]);
        chk({name, "_data"}, wl_data[i], datas[i]);
      end
    end
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_in_ready"}, in_ready, 0);
    chk({name, "_w_en"}, w_en, 0);
    chk({name, "_w_addr"}, w_addr, 0);
    chk({name, "_w_data"}, w_data, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
  endtask

  initial begin
    int s, d0, k;
    int q[$], a[$], e[$];
    bit acc;

    tick(); tick();
    check_zero_outputs("reset");
    reset = 1'b0;

    // in_valid while idle must not produce a write
    clear_log();
    w_grant = 1'b1; in_valid = 1'b1; in_data = 16'd123;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("idle_valid_nwrites", wl_addr.size(), 0);

    // basic job
    clear_log(); d0 = done_cnt;
    start_job(12'h100, 3, 2, 5, s);
    chk("basic_busy_s1", busy, 1);
    chk("basic_ready_s1", in_ready, 1);
    q = {100, -8, 40}; feed(q);
    wait_done(d0);
    a = {12'h100, 12'h101, 12'h102}; e = {30, 3, 15};
    check_writes("basic", a, e);
    if (wl_cyc.size() == 3) begin
      chk("basic_consec1", wl_cyc[1] - wl_cyc[0], 1);
      chk("basic_consec2", wl_cyc[2] - wl_cyc[1], 1);
      chk("basic_done_after_last", done_cyc - wl_cyc[2], 1);
    end
    chk("basic_done_latency", done_cyc - s, 4);
    chk("basic_idle_after", busy, 0);

    // saturation
    clear_log(); d0 = done_cnt;
    start_job(12'h010, 1, 0, 100, s); q = {32700}; feed(q); wait_done(d0);
    d0 = done_cnt;
    start_job(12'h020, 1, 0, -100, s); q = {-32700}; feed(q); wait_done(d0);
    d0 = done_cnt;
    start_job(12'h030, 1, 15, 7, s); q = {-1}; feed(q); wait_done(d0);
    a = {12'h010, 12'h020, 12'h030}; e = {32767, -32768, 6};
    check_writes("sat", a, e);

    // backpressure: grant low, 9 results, FIFO holds 8
    clear_log(); d0 = done_cnt;
    w_grant = 1'b0;
    q.delete(); for (int i = 0; i < 9; i++) q.push_back(i * 1000 - 3000);
    start_job(12'h200, 9, 0, 0, s);
    k = 0; in_valid = 1'b1; in_data = 16'(q[0]);
    for (int i = 0; i < 12; i++) begin
      acc = in_ready; tick();
      if (acc) k++;
      in_data = 16'(q[(k < 9) ? k : 8]);
    end
    chk("bp_accepts", k, 8);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_no_writes", wl_addr.size(), 0);
    w_grant = 1'b1;
    for (int i = 0; i < 20 && k < 9; i++) begin
      acc = in_ready; tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", k, 9);
    wait_done(d0);
    a.delete(); for (int i = 0; i < 9; i++) a.push_back(12'h200 + i);
    check_writes("bp", a, q);

    // address wrap
    clear_log(); d0 = done_cnt;
    start_job(12'hFFE, 4, 0, 0, s); q = {1, 2, 3, 4}; feed(q); wait_done(d0);
    a = {12'hFFE, 12'hFFF, 0, 1}; e = {1, 2, 3, 4};
    check_writes("wrap", a, e);

    // count zero
    clear_log(); d0 = done_cnt;
    start_job(12'h050, 0, 0, 0, s);
    repeat (3) tick();
    chk("cnt0_done_count", done_cnt, d0 + 1);
    chk("cnt0_done_cycle", done_cyc, s);
    chk("cnt0_no_writes", wl_addr.size(), 0);

    // second start during RUN is ignored
    clear_log(); d0 = done_cnt;
    start_job(12'h300, 2, 0, 0, s);
    in_valid = 1'b1; in_data = 16'd11;
    base_addr = 12'h007; count = 8'd5; start = 1'b1;
    tick();
    start = 1'b0; in_data = 16'd22;
    tick();
    in_valid = 1'b0;
    wait_done(d0);
    a = {12'h300, 12'h301}; e = {11, 22};
    check_writes("restart", a, e);

    // mid-job reset, then a fresh job
    clear_log(); d0 = done_cnt;
    w_grant = 1'b0;
    start_job(12'h400, 5, 0, 0, s); q = {5, 6}; feed(q);
    reset = 1'b1;
    tick();
    check_zero_outputs("midreset");
    reset = 1'b0;
    repeat (3) tick();
    chk("midreset_no_done", done_cnt, d0);
    chk("midreset_no_writes", wl_addr.size(), 0);
    w_grant = 1'b1; d0 = done_cnt;
    start_job(12'h410, 2, 1, 0, s); q = {8, -9}; feed(q); wait_done(d0);
    a = {12'h410, 12'h411}; e = {4, -5};
    check_writes("fresh", a, e);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
